// File: rtl/rf.sv
// rf: 32 x 32 register file with two combinational read ports and one synchronous write port.
// Optional macro RF_ZERO_REG_EN hardwires register 0 to zero (writes ignored, reads return 0).
module rf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] regRNum1,
    input  logic [ADDR_WIDTH-1:0] regRNum2,
    input  logic [ADDR_WIDTH-1:0] wReg,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] rData1,
    output logic [DATA_WIDTH-1:0] rData2
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      wr_en;

    // One-hot write decode; register 0 drops out of the decode when hardwired.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
`ifdef RF_ZERO_REG_EN
        if (gi == 0) begin : g_zero
            assign wr_en[gi] = 1'b0;
        end else begin : g_norm
            assign wr_en[gi] = RegWrite && (wReg == ADDR_WIDTH'(gi));
        end
`else
        assign wr_en[gi] = RegWrite && (wReg == ADDR_WIDTH'(gi));
`endif
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                regs_d[i] = data;
            end
        end
    end

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No write bypass: reads see the stored value until the write edge.
`ifdef RF_ZERO_REG_EN
    assign rData1 = (regRNum1 == '0) ? '0 : regs_q[regRNum1];
    assign rData2 = (regRNum2 == '0) ? '0 : regs_q[regRNum2];
`else
    assign rData1 = regs_q[regRNum1];
    assign rData2 = regs_q[regRNum2];
`endif

endmodule

// File: tb/tb_rf.sv
// Directed self-checking bench for rf: reset, fill, write disable, read-during-write,
// reset priority and the register-0 behaviour selected by RF_ZERO_REG_EN.
module tb_rf;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] regRNum1 = '0;
    logic [AW-1:0] regRNum2 = '0;
    logic [AW-1:0] wReg = '0;
    logic [DW-1:0] data = '0;
    logic          RegWrite = 1'b0;
    logic [DW-1:0] rData1;
    logic [DW-1:0] rData2;

    int checks = 0;
    int errors = 0;

    rf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .regRNum1 (regRNum1),
        .regRNum2 (regRNum2),
        .wReg     (wReg),
        .data     (data),
        .RegWrite (RegWrite),
        .rData1   (rData1),
        .rData2   (rData2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RegWrite = 1'b0;
        tick();
        reset = 1'b0;
        for (int a = 0; a < N; a++) begin
            regRNum1 = AW'(a);
            regRNum2 = AW'(N - 1 - a);
            #1;
            checks++;
            if (rData1 !== '0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%0d expected=0", a, rData1);
            end
            checks++;
            if (rData2 !== '0) begin
                errors++;
                $display("FAIL reset_rd2 addr=%0d got=%0d expected=0", N - 1 - a, rData2);
            end
        end
        $display("test_reset: all %0d addresses checked on both ports", N);
    endtask

    task automatic test_fill();
        logic [DW-1:0] e1, e2;
        for (int k = 0; k < N; k++) begin
            wReg = AW'(k);
            data = DW'(k * 10);
            RegWrite = 1'b1;
            tick();
        end
        RegWrite = 1'b0;
        for (int k = 0; k < N; k += 2) begin
            regRNum1 = AW'(k);
            regRNum2 = AW'(k + 1);
            #1;
            e1 = (ZERO_EN && k == 0) ? '0 : DW'(k * 10);
            e2 = DW'((k + 1) * 10);
            checks++;
            if (rData1 !== e1) begin
                errors++;
                $display("FAIL fill_rd1 addr=%0d got=%0d expected=%0d", k, rData1, e1);
            end
            checks++;
            if (rData2 !== e2) begin
                errors++;
                $display("FAIL fill_rd2 addr=%0d got=%0d expected=%0d", k + 1, rData2, e2);
            end
            $display("test_fill: r[%0d]=%0d r[%0d]=%0d", k, rData1, k + 1, rData2);
        end
    endtask

    task automatic test_write_disable();
        wReg = 5'd5;
        data = 32'd999;
        RegWrite = 1'b0;
        regRNum1 = 5'd5;
        regRNum2 = 5'd5;
        tick();
        checks++;
        if (rData1 !== 32'd50) begin
            errors++;
            $display("FAIL wr_disable_rd1 got=%0d expected=50", rData1);
        end
        checks++;
        if (rData2 !== 32'd50) begin
            errors++;
            $display("FAIL wr_disable_rd2 got=%0d expected=50", rData2);
        end
        $display("test_write_disable: r[5]=%0d", rData1);
    endtask

    task automatic test_read_during_write();
        regRNum1 = 5'd7;
        regRNum2 = 5'd7;
        wReg = 5'd7;
        data = 32'd123;
        RegWrite = 1'b1;
        #1;
        checks++;
        if (rData1 !== 32'd70) begin
            errors++;
            $display("FAIL rdw_before got=%0d expected=70", rData1);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rData1 !== 32'd123) begin
            errors++;
            $display("FAIL rdw_after_rd1 got=%0d expected=123", rData1);
        end
        checks++;
        if (rData2 !== 32'd123) begin
            errors++;
            $display("FAIL rdw_after_rd2 got=%0d expected=123", rData2);
        end
        // Neighbouring register must be untouched by the write to 7.
        regRNum2 = 5'd8;
        #1;
        checks++;
        if (rData2 !== 32'd80) begin
            errors++;
            $display("FAIL rdw_neighbour got=%0d expected=80", rData2);
        end
        $display("test_read_during_write: r[7]=%0d r[8]=%0d", rData1, rData2);
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        RegWrite = 1'b1;
        wReg = 5'd3;
        data = 32'd77;
        tick();
        reset = 1'b0;
        RegWrite = 1'b0;
        for (int a = 0; a < N; a++) begin
            regRNum1 = AW'(a);
            regRNum2 = AW'(a ^ 1);
            #1;
            checks++;
            if (rData1 !== '0) begin
                errors++;
                $display("FAIL rst_prio_rd1 addr=%0d got=%0d expected=0", a, rData1);
            end
            checks++;
            if (rData2 !== '0) begin
                errors++;
                $display("FAIL rst_prio_rd2 addr=%0d got=%0d expected=0", a ^ 1, rData2);
            end
        end
        $display("test_reset_priority: write to r[3] discarded, all registers 0");
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] e;
        e = ZERO_EN ? '0 : 32'd55;
        wReg = 5'd0;
        data = 32'd55;
        RegWrite = 1'b1;
        regRNum1 = 5'd0;
        regRNum2 = 5'd0;
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rData1 !== e) begin
            errors++;
            $display("FAIL zero_reg_rd1 got=%0d expected=%0d", rData1, e);
        end
        checks++;
        if (rData2 !== e) begin
            errors++;
            $display("FAIL zero_reg_rd2 got=%0d expected=%0d", rData2, e);
        end
        $display("test_zero_reg: r[0]=%0d (zero_en=%0d)", rData1, ZERO_EN);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_disable();
        test_read_during_write();
        test_reset_priority();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
